core_lsu: RTL and testbench

CORE_LSU -- requirements
Module: core_lsu

---
 rtl/core_lsu.sv | 158 +++++++++++++++
 tb/tb_core_lsu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
// Load/store unit: one outstanding access on a simple wait-request bus.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned H/W accesses into errors.
module core_lsu #(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_st,
  input  logic [3:0]  req_mem_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] bus_addr,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_byteenable,
  input  logic        bus_waitrequest,
  input  logic        bus_readdatavalid,
  input  logic [31:0] bus_readdata,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_rdata,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);
  localparam logic [3:0] MEM_OP_B  = 4'd1;
  localparam logic [3:0] MEM_OP_H  = 4'd2;
  localparam logic [3:0] MEM_OP_W  = 4'd3;
  localparam logic [3:0] MEM_OP_BU = 4'd4;
  localparam logic [3:0] MEM_OP_HU = 4'd5;
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUS, WAIT_RD, DONE} state_t;
  state_t state, next_state;

  logic          is_st_q, err_q;
  logic [3:0]    op_q;
  logic [1:0]    off_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] tmo_cnt;

  logic          illegal, misaligned, tmo_last;
  logic [31:0]   eff_addr, st_data, ld_shift, ld_data;
  logic [3:0]    st_be;

  // Request decode: effective (possibly force-aligned) address, lanes and store data.
  always_comb begin
    illegal    = (req_mem_op == 4'd0) || (req_mem_op > MEM_OP_HU);
    misaligned = 1'b0;
    eff_addr   = req_addr;
    st_be      = 4'b1111;
    st_data    = req_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
    if (req_mem_op == MEM_OP_H || req_mem_op == MEM_OP_HU) misaligned = req_addr[0];
    if (req_mem_op == MEM_OP_W) misaligned = |req_addr[1:0];
`else
    if (req_mem_op == MEM_OP_H || req_mem_op == MEM_OP_HU) eff_addr[0] = 1'b0;
    if (req_mem_op == MEM_OP_W) eff_addr[1:0] = 2'b00;
`endif
    case (req_mem_op)
      MEM_OP_B, MEM_OP_BU: begin
        st_be   = 4'b0001 << eff_addr[1:0];
        st_data = {4{req_wdata[7:0]}};
      end
      MEM_OP_H, MEM_OP_HU: begin
        st_be   = 4'b0011 << {eff_addr[1], 1'b0};
        st_data = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = bus_readdata >> {off_q, 3'b000};
    ld_data  = ld_shift;
    case (op_q)
      MEM_OP_B:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      MEM_OP_BU: ld_data = {24'd0, ld_shift[7:0]};
      MEM_OP_H:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      MEM_OP_HU: ld_data = {16'd0, ld_shift[15:0]};
      default: ;
    endcase
  end

  assign tmo_last = (tmo_cnt == TMO_LAST);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (illegal || misaligned) ? DONE : BUS;
      BUS:     if (!bus_waitrequest) next_state = is_st_q ? DONE : WAIT_RD;
               else if (tmo_last)    next_state = DONE;
      WAIT_RD: if (bus_readdatavalid || tmo_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Datapath registers; the counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_st_q <= 1'b0; err_q <= 1'b0; op_q <= 4'd0; off_q <= 2'd0; addr_q <= 32'd0;
      tmo_cnt <= '0;
      bus_addr <= 32'd0; bus_wdata <= 32'd0; bus_byteenable <= 4'd0;
      resp_rd <= 5'd0; resp_rdata <= 32'd0; err_code <= 2'd0; err_addr <= 32'd0;
    end else begin
      if (state != next_state) tmo_cnt <= '0;
      else if (state == BUS || state == WAIT_RD) tmo_cnt <= tmo_cnt + 1'b1;
      case (state)
        IDLE: if (req_valid) begin
          is_st_q    <= req_is_st;
          op_q       <= req_mem_op;
          off_q      <= eff_addr[1:0];
          addr_q     <= req_addr;
          resp_rd    <= req_rd;
          resp_rdata <= 32'd0;
          err_q      <= illegal || misaligned;
          if (illegal || misaligned) begin
            err_code <= illegal ? 2'd2 : 2'd1;
            err_addr <= req_addr;
          end else begin
            bus_addr       <= {eff_addr[31:2], 2'b00};
            bus_byteenable <= st_be;
            bus_wdata      <= st_data;
          end
        end
        BUS: if (bus_waitrequest && tmo_last) begin
          err_q <= 1'b1; err_code <= 2'd3; err_addr <= addr_q;
        end
        WAIT_RD: begin
          if (bus_readdatavalid) resp_rdata <= ld_data;
          else if (tmo_last) begin
            err_q <= 1'b1; err_code <= 2'd3; err_addr <= addr_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign bus_read   = (state == BUS) && !is_st_q;
  assign bus_write  = (state == BUS) && is_st_q;
  assign resp_valid = (state == DONE) && !err_q;
  assign resp_we    = resp_valid && !is_st_q;
  assign err_valid  = (state == DONE) && err_q;
endmodule

// File: tb/tb_core_lsu.sv
// Directed bench for core_lsu: bus slave and requester are driven step by step on
// the falling edge; outputs are checked there against hand-computed values.
module tb_core_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_st;
  logic [3:0]  req_mem_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] bus_addr, bus_wdata, bus_readdata;
  logic        bus_read, bus_write, bus_waitrequest, bus_readdatavalid;
  logic [3:0]  bus_byteenable;
  logic        resp_valid, resp_we, err_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata, err_addr;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] OP_B = 4'd1, OP_H = 4'd2, OP_W = 4'd3, OP_BU = 4'd4, OP_HU = 4'd5;

  core_lsu #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_st(req_is_st),
    .req_mem_op(req_mem_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_byteenable(bus_byteenable), .bus_waitrequest(bus_waitrequest),
    .bus_readdatavalid(bus_readdatavalid), .bus_readdata(bus_readdata),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single accept edge; returns on the first falling edge
  // after acceptance (DUT now in BUS or DONE).
  task automatic issue(input logic st, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] rd);
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_st = st; req_mem_op = op; req_addr = a; req_wdata = d; req_rd = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Full load with zero wait states and data one cycle after the strobe.
  task automatic do_load(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    issue(1'b0, op, a, 32'd0, rd);
    bus_waitrequest = 1'b0;
    chk({tag, "_bus_read"}, {31'd0, bus_read}, 32'd1);
    chk({tag, "_bus_addr"}, bus_addr, exp_addr);
    chk({tag, "_be"}, {28'd0, bus_byteenable}, {28'd0, exp_be});
    @(negedge clk);
    chk({tag, "_strobe_off"}, {31'd0, bus_read}, 32'd0);
    bus_readdatavalid = 1'b1; bus_readdata = rdata;
    @(negedge clk);
    bus_readdatavalid = 1'b0;
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_resp_we"}, {31'd0, resp_we}, 32'd1);
    chk({tag, "_resp_rd"}, {27'd0, resp_rd}, {27'd0, rd});
    chk({tag, "_rdata"}, resp_rdata, exp_data);
    chk({tag, "_no_err"}, {31'd0, err_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_st = 1'b0; req_mem_op = 4'd0;
    req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
    bus_waitrequest = 1'b0; bus_readdatavalid = 1'b0; bus_readdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {30'd0, bus_read, bus_write}, 32'd0);
    chk("rst_resp_err", {30'd0, resp_valid, err_valid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_be", {28'd0, bus_byteenable}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    rst = 1'b0;

    // Store word, no wait states: strobe at N+1, response at N+2.
    issue(1'b1, OP_W, 32'h100, 32'hDEADBEEF, 5'd0);
    chk("sw_bus_write", {31'd0, bus_write}, 32'd1);
    chk("sw_bus_read", {31'd0, bus_read}, 32'd0);
    chk("sw_bus_addr", bus_addr, 32'h100);
    chk("sw_be", {28'd0, bus_byteenable}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    chk("sw_not_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("sw_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sw_resp_we", {31'd0, resp_we}, 32'd0);
    chk("sw_rdata_zero", resp_rdata, 32'd0);
    chk("sw_strobe_off", {31'd0, bus_write}, 32'd0);

    // Byte loads from the top lane, signed and unsigned.
    do_load("lb", OP_B, 32'h203, 32'h80000000, 5'd7, 32'h200, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", OP_BU, 32'h203, 32'h80000000, 5'd8, 32'h200, 4'b1000, 32'h00000080);
    do_load("lh", OP_H, 32'h206, 32'h80010000, 5'd9, 32'h204, 4'b1100, 32'hFFFF8001);
    do_load("lhu", OP_HU, 32'h206, 32'h80010000, 5'd10, 32'h204, 4'b1100, 32'h00008001);

    // Store halfword with three wait-state cycles: strobe held four cycles.
    issue(1'b1, OP_H, 32'h102, 32'h1234ABCD, 5'd0);
    for (int i = 0; i < 4; i++) begin
      bus_waitrequest = (i < 3);
      chk("sh_bus_write", {31'd0, bus_write}, 32'd1);
      chk("sh_wdata", bus_wdata, 32'hABCDABCD);
      chk("sh_be", {28'd0, bus_byteenable}, 32'hC);
      chk("sh_bus_addr", bus_addr, 32'h100);
      @(negedge clk);
    end
    bus_waitrequest = 1'b0;
    chk("sh_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("sh_no_err", {31'd0, err_valid}, 32'd0);

    // Misaligned word load at 0x101.
`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b0, OP_W, 32'h101, 32'd0, 5'd3);
    chk("lw_mis_err_valid", {31'd0, err_valid}, 32'd1);
    chk("lw_mis_code", {30'd0, err_code}, 32'd1);
    chk("lw_mis_addr", err_addr, 32'h101);
    chk("lw_mis_no_read", {31'd0, bus_read}, 32'd0);
    chk("lw_mis_no_resp", {31'd0, resp_valid}, 32'd0);
`else
    do_load("lw_mis", OP_W, 32'h101, 32'hCAFEF00D, 5'd3, 32'h100, 4'b1111, 32'hCAFEF00D);
`endif

    // Illegal op 7: straight to error, no bus access.
    issue(1'b0, 4'd7, 32'h444, 32'd0, 5'd1);
    chk("ill_err_valid", {31'd0, err_valid}, 32'd1);
    chk("ill_code", {30'd0, err_code}, 32'd2);
    chk("ill_addr", err_addr, 32'h444);
    chk("ill_no_read", {31'd0, bus_read}, 32'd0);
    chk("ill_no_resp", {31'd0, resp_valid}, 32'd0);

    // Read-data timeout after four cycles in WAIT_RD.
    issue(1'b0, OP_W, 32'h300, 32'd0, 5'd4);
    chk("tmo_bus_read", {31'd0, bus_read}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo_waiting", {30'd0, err_valid, resp_valid}, 32'd0);
      chk("tmo_strobe_off", {31'd0, bus_read}, 32'd0);
    end
    @(negedge clk);
    chk("tmo_err_valid", {31'd0, err_valid}, 32'd1);
    chk("tmo_code", {30'd0, err_code}, 32'd3);
    chk("tmo_addr", err_addr, 32'h300);
    chk("tmo_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("tmo_ready_after", {31'd0, req_ready}, 32'd1);

    // Reset while waiting for read data; late data must be ignored.
    issue(1'b0, OP_W, 32'h500, 32'd0, 5'd5);
    @(negedge clk);
    chk("rstmid_in_wait", {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_readdatavalid = 1'b1; bus_readdata = 32'h11223344;
    @(negedge clk);
    bus_readdatavalid = 1'b0;
    chk("rstmid_no_resp", {30'd0, resp_valid, err_valid}, 32'd0);
    chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
    chk("rstmid_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    chk("rstmid_still_quiet", {30'd0, resp_valid, err_valid}, 32'd0);

    // Byte store into lane 1 replicates the byte.
    issue(1'b1, OP_B, 32'h0000_0041, 32'h000000A5, 5'd0);
    chk("sb_be", {28'd0, bus_byteenable}, 32'h2);
    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
    chk("sb_addr", bus_addr, 32'h40);
    @(negedge clk);
    chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
